// File: rtl/median_filter_stream.sv
// ============================================================================
// Module      : median_filter_stream
// Description : Streaming 3x3 median filter over a raster pixel stream.
//               Two line buffers and a 3x3 window feed a 19 compare-exchange
//               median network split over three pipeline stages. Only
//               interior windows are emitted, with sof/eol/eof markers.
//               Optional feature macro: MEDIAN_BYPASS_EN (adds a per-frame
//               bypass input that outputs the window centre instead).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_filter_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 100,
    parameter int IMG_H = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MEDIAN_BYPASS_EN
    ,
    input  logic             bypass
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_col_two  = CW'(2);
    localparam logic [RW-1:0] c_row_two  = RW'(2);

    // Window flattened as index = row*3 + col, row 0 = oldest line, col 0 = oldest column.
    typedef logic [8:0][PIX_W-1:0] win_t;

    // Compare-exchange: lower value to index a, higher to index b.
    function automatic win_t cas(input win_t v, input logic [3:0] a, input logic [3:0] b);
        win_t r;
        r = v;
        if (v[a] > v[b]) begin
            r[a] = v[b];
            r[b] = v[a];
        end
        return r;
    endfunction

    // First 9 exchanges: sort each row of three.
    function automatic win_t net_s1(input win_t v);
        win_t t;
        t = v;
        t = cas(t, 4'd1, 4'd2); t = cas(t, 4'd4, 4'd5); t = cas(t, 4'd7, 4'd8);
        t = cas(t, 4'd0, 4'd1); t = cas(t, 4'd3, 4'd4); t = cas(t, 4'd6, 4'd7);
        t = cas(t, 4'd1, 4'd2); t = cas(t, 4'd4, 4'd5); t = cas(t, 4'd7, 4'd8);
        return t;
    endfunction

    // Next 6 exchanges: max of mins, min of maxes, and the middle column.
    function automatic win_t net_s2(input win_t v);
        win_t t;
        t = v;
        t = cas(t, 4'd0, 4'd3); t = cas(t, 4'd5, 4'd8); t = cas(t, 4'd4, 4'd7);
        t = cas(t, 4'd3, 4'd6); t = cas(t, 4'd1, 4'd4); t = cas(t, 4'd2, 4'd5);
        return t;
    endfunction

    // Last 4 exchanges: median lands in index 4.
    function automatic win_t net_s3(input win_t v);
        win_t t;
        t = v;
        t = cas(t, 4'd4, 4'd7); t = cas(t, 4'd4, 4'd2);
        t = cas(t, 4'd6, 4'd4); t = cas(t, 4'd4, 4'd2);
        return t;
    endfunction

    logic             w_adv;
    logic             w_acc;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic             w_full;
    logic             w_byp;
    logic [PIX_W-1:0] w_lb0_rd;
    logic [PIX_W-1:0] w_lb1_rd;
    win_t             w_s1;
    win_t             w_s2;
    win_t             w_s3;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_lb0 [IMG_W];
    logic [PIX_W-1:0] r_lb1 [IMG_W];

    win_t             r_win;
    logic             r_v0_vld, r_v0_sof, r_v0_eol, r_v0_eof, r_v0_byp;
    win_t             r_s1;
    logic [PIX_W-1:0] r_s1_ctr;
    logic             r_s1_vld, r_s1_sof, r_s1_eol, r_s1_eof, r_s1_byp;
    win_t             r_s2;
    logic [PIX_W-1:0] r_s2_ctr;
    logic             r_s2_vld, r_s2_sof, r_s2_eol, r_s2_eof, r_s2_byp;

    // Whole pipeline advances together whenever the output slot can move.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_acc    = in_valid && w_adv;

    // Position of the pixel being offered; sof forces a resync to (0,0).
    assign w_col  = in_sof ? '0 : r_col;
    assign w_row  = in_sof ? '0 : r_row;
    assign w_full = (w_row >= c_row_two) && (w_col >= c_col_two);

    assign w_lb0_rd = r_lb0[w_col];
    assign w_lb1_rd = r_lb1[w_col];

`ifdef MEDIAN_BYPASS_EN
    logic r_byp;

    // Bypass mode is latched on the frame's first pixel and held for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_byp <= 1'b0;
        else if (w_acc && in_sof)
            r_byp <= bypass;
    end

    assign w_byp = in_sof ? bypass : r_byp;
`else
    assign w_byp = 1'b0;
`endif

    // Raster position counters, one step per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col == c_col_last) begin
                r_col <= '0;
                r_row <= (w_row == c_row_last) ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    // Line buffers: lb0 holds the previous line, lb1 the one before it; never cleared.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb1[w_col] <= w_lb0_rd;
            r_lb0[w_col] <= in_pix;
        end
    end

    // Window shift and token injection (stage 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win    <= '0;
            r_v0_vld <= 1'b0;
            r_v0_sof <= 1'b0;
            r_v0_eol <= 1'b0;
            r_v0_eof <= 1'b0;
            r_v0_byp <= 1'b0;
        end else if (w_adv) begin
            r_v0_vld <= w_acc && w_full;
            r_v0_sof <= w_acc && w_full && (w_row == c_row_two) && (w_col == c_col_two);
            r_v0_eol <= w_acc && w_full && (w_col == c_col_last);
            r_v0_eof <= w_acc && w_full && (w_col == c_col_last) && (w_row == c_row_last);
            r_v0_byp <= w_byp;
            if (w_acc) begin
                r_win[0] <= r_win[1]; r_win[1] <= r_win[2]; r_win[2] <= w_lb1_rd;
                r_win[3] <= r_win[4]; r_win[4] <= r_win[5]; r_win[5] <= w_lb0_rd;
                r_win[6] <= r_win[7]; r_win[7] <= r_win[8]; r_win[8] <= in_pix;
            end
        end
    end

    assign w_s1 = net_s1(r_win);
    assign w_s2 = net_s2(r_s1);
    assign w_s3 = net_s3(r_s2);

    // Median stage S1 register (row sorts); centre pixel carried for bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s1_ctr <= '0;
            r_s1_vld <= 1'b0;
            r_s1_sof <= 1'b0;
            r_s1_eol <= 1'b0;
            r_s1_eof <= 1'b0;
            r_s1_byp <= 1'b0;
        end else if (w_adv) begin
            r_s1     <= w_s1;
            r_s1_ctr <= r_win[4];
            r_s1_vld <= r_v0_vld;
            r_s1_sof <= r_v0_sof;
            r_s1_eol <= r_v0_eol;
            r_s1_eof <= r_v0_eof;
            r_s1_byp <= r_v0_byp;
        end
    end

    // Median stage S2 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2     <= '0;
            r_s2_ctr <= '0;
            r_s2_vld <= 1'b0;
            r_s2_sof <= 1'b0;
            r_s2_eol <= 1'b0;
            r_s2_eof <= 1'b0;
            r_s2_byp <= 1'b0;
        end else if (w_adv) begin
            r_s2     <= w_s2;
            r_s2_ctr <= r_s1_ctr;
            r_s2_vld <= r_s1_vld;
            r_s2_sof <= r_s1_sof;
            r_s2_eol <= r_s1_eol;
            r_s2_eof <= r_s1_eof;
            r_s2_byp <= r_s1_byp;
        end
    end

    // Output register (stage S3): median or, in bypass, the window centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pix   <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            out_valid <= 1'b0;
        end else if (w_adv) begin
            out_pix   <= r_s2_byp ? r_s2_ctr : w_s3[4];
            out_sof   <= r_s2_sof;
            out_eol   <= r_s2_eol;
            out_eof   <= r_s2_eof;
            out_valid <= r_s2_vld;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_median_filter_stream.sv
// ============================================================================
// Module      : tb_median_filter_stream
// Description : Scoreboard bench for median_filter_stream on a 5x5 image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_median_filter_stream;

    localparam int W = 5;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_pix = '0;
    logic       in_sof = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_pix;
    logic       out_sof, out_eol, out_eof, out_valid;
    logic       out_ready = 1'b1;
`ifdef MEDIAN_BYPASS_EN
    logic       bypass = 1'b0;
`endif

    median_filter_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pix    (in_pix),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pix   (out_pix),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MEDIAN_BYPASS_EN
        ,
        .bypass    (bypass)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
        int         edge_n;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_neg  = 0;
    int         outs   = 0;
    int         cyc    = 0;
    int         m_row  = 0;
    int         m_col  = 0;
    bit         m_byp  = 1'b0;
    bit         lat_chk = 1'b0;
    bit         rdy_tog = 1'b0;
    bit         hold_v = 1'b0;
    logic [7:0] hold_pix;
    logic [7:0] img [H][W];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_median(input int cr, input int cc);
        logic [7:0] v [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) v[i] = img[cr - 1 + i / 3][cc - 1 + i % 3];
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0; j--)
                if (v[j-1] > v[j]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
        return v[4];
    endfunction

    function automatic logic [7:0] pix_of(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'h40;
            1:       return (r == 2 && c == 2) ? 8'hFF : 8'h00;
            default: return 8'(c * 10);
        endcase
    endfunction

    // Monitor: sample between edges, compare outputs and model accepted input.
    always @(negedge clk) begin
        exp_t e;
        int   r, c;
        n_neg++;
        if (!rst) begin
            if (hold_v)
                check_val("stall_hold", {23'd0, out_valid, out_pix}, {23'd0, 1'b1, hold_pix});
            hold_v   = out_valid && !out_ready;
            hold_pix = out_pix;
            if (out_valid && !out_ready)
                check_val("in_ready_stall", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                outs++;
                check_val("out_expected", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check_val("out_pix", {24'd0, out_pix}, {24'd0, e.pix});
                    check_val("out_sof", {31'd0, out_sof}, {31'd0, e.sof});
                    check_val("out_eol", {31'd0, out_eol}, {31'd0, e.eol});
                    check_val("out_eof", {31'd0, out_eof}, {31'd0, e.eof});
                    if (lat_chk)
                        check_val("latency", n_neg - e.edge_n, 32'd3);
                end
            end
            if (in_valid && in_ready) begin
                r = in_sof ? 0 : m_row;
                c = in_sof ? 0 : m_col;
`ifdef MEDIAN_BYPASS_EN
                if (in_sof) m_byp = bypass;
`endif
                img[r][c] = in_pix;
                if (r >= 2 && c >= 2) begin
                    e.pix    = m_byp ? img[r-1][c-1] : ref_median(r - 1, c - 1);
                    e.sof    = (r - 1 == 1) && (c - 1 == 1);
                    e.eol    = (c - 1 == W - 2);
                    e.eof    = (r - 1 == H - 2) && (c - 1 == W - 2);
                    e.edge_n = n_neg + 1;
                    q.push_back(e);
                end
                if (c == W - 1) begin
                    m_col = 0;
                    m_row = (r == H - 1) ? 0 : r + 1;
                end else begin
                    m_col = c + 1;
                    m_row = r;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        out_ready = rdy_tog ? cyc[0] : 1'b1;
    endtask

    task automatic send_pix(input logic [7:0] p, input logic s);
        int g;
        bit acc;
        g = 0;
        in_pix = p;
        in_sof = s;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            g++;
            if (g > 100) begin
                check_val("accept_timeout", g, 32'd0);
                break;
            end
        end
    endtask

    task automatic run_pixels(input int mode, input int npix);
        for (int i = 0; i < npix; i++)
            send_pix(pix_of(mode, i / W, i % W), i == 0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit tog, input bit lat);
        int g;
        outs    = 0;
        lat_chk = lat;
        rdy_tog = tog;
        run_pixels(mode, W * H);
        g = 0;
        while ((q.size() != 0 || out_valid) && g < 100) begin
            tick();
            g++;
        end
        check_val("drain_queue", q.size(), 32'd0);
        check_val("out_count", outs, (H - 2) * (W - 2));
        rdy_tog = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_pix", {24'd0, out_pix}, 32'd0);
        q.delete();
        m_row  = 0;
        m_col  = 0;
        hold_v = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_pix", {24'd0, out_pix}, 32'd0);
        check_val("reset_markers", {29'd0, out_sof, out_eol, out_eof}, 32'd0);
        check_val("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        run_frame(0, 1'b0, 1'b1);  // constant 0x40
        run_frame(1, 1'b0, 1'b1);  // impulse removal
        run_frame(2, 1'b0, 1'b1);  // horizontal ramp
        run_frame(2, 1'b1, 1'b0);  // ramp with alternating out_ready

        lat_chk = 1'b1;
        run_pixels(0, 12);         // reset before any output exists
        apply_reset();
        run_pixels(0, 17);         // reset while outputs are in flight
        check_val("valid_before_rst", {31'd0, out_valid}, 32'd1);
        apply_reset();
        run_frame(0, 1'b0, 1'b1);  // frame after reset matches the first one

`ifdef MEDIAN_BYPASS_EN
        bypass = 1'b1;
        run_frame(1, 1'b0, 1'b1);  // centre passthrough keeps the impulse
        bypass = 1'b0;
        run_frame(1, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
